// File: rtl/warp_lsu_if.sv
// Memory request/response channel between the warp LSU and the memory port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface warp_lsu_if #(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_write;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/warp_lsu.sv
// Per-warp load/store unit: serialises the enabled threads of a warp onto one
// memory port with a single outstanding request.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module warp_lsu #(
  parameter int unsigned THREADS_PER_WARP = 16,
  parameter int unsigned DATA_WIDTH       = `DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH       = 32
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic                                       decoded_mem_read_enable,
  input  logic                                       decoded_mem_write_enable,
  input  logic [DATA_WIDTH-1:0]                      decoded_immediate,
  input  logic [THREADS_PER_WARP-1:0]                thread_enable,
  input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] rs1,
  input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] rs2,
  warp_lsu_if.master                                 mem,
  output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] lsu_out,
  output logic                                       busy,
  output logic                                       done
);

  localparam int unsigned TID_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
  typedef logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] lane_data_t;

  state_t                      state_q, state_d;
  logic [THREADS_PER_WARP-1:0] pending_q, pending_d;
  lane_data_t                  rs1_q, rs1_d, rs2_q, rs2_d, lsu_out_q, lsu_out_d;
  logic [DATA_WIDTH-1:0]       imm_q, imm_d;
  logic                        is_load_q, is_load_d;
  logic [TID_W-1:0]            cur_q, cur_d;
  logic                        req_valid_q, req_valid_d;
  logic                        req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0]       req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]       req_wdata_q, req_wdata_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        issue;

  // Lowest-index set bit; disabled threads are skipped without costing cycles.
  function automatic logic [TID_W-1:0] lowest_set(input logic [THREADS_PER_WARP-1:0] m);
    lowest_set = '0;
    for (int i = int'(THREADS_PER_WARP) - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = TID_W'(i);
    end
  endfunction

  // Next-state logic; request fields are precomputed so they leave a register.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    is_load_d   = is_load_q;
    cur_d       = cur_q;
    lsu_out_d   = lsu_out_q;
    req_valid_d = 1'b0;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    issue       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rs1_d     = rs1;
          rs2_d     = rs2;
          imm_d     = decoded_immediate;
          is_load_d = decoded_mem_read_enable;
          pending_d = thread_enable;
          if (!(decoded_mem_read_enable || decoded_mem_write_enable) || (thread_enable == '0)) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            issue   = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem.mem_req_ready) begin
          state_d = WAIT_RSP;
        end else begin
          req_valid_d = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (mem.mem_rsp_valid) begin
          if (is_load_q) lsu_out_d[cur_q] = mem.mem_rsp_rdata;
          pending_d[cur_q] = 1'b0;
          if (pending_d == '0) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            issue   = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue) begin
      cur_d       = lowest_set(pending_d);
      req_valid_d = 1'b1;
      req_write_d = !is_load_d;
      req_addr_d  = ADDR_WIDTH'(rs1_d[cur_d] + imm_d);
      req_wdata_d = rs2_d[cur_d];
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      is_load_q   <= 1'b0;
      cur_q       <= '0;
      lsu_out_q   <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      is_load_q   <= is_load_d;
      cur_q       <= cur_d;
      lsu_out_q   <= lsu_out_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_write = req_write_q;
  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_wdata = req_wdata_q;
  assign lsu_out           = lsu_out_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_warp_lsu.sv
// Scoreboard bench for warp_lsu: expected requests are queued at start and
// matched against each request handshake; load results tracked per thread.
module tb_warp_lsu;
  localparam int unsigned T  = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic                 clk = 1'b0;
  logic                 reset, start, rd_en, wr_en;
  logic [DW-1:0]        imm;
  logic [T-1:0]         mask;
  logic [T-1:0][DW-1:0] rs1, rs2, lsu_out;
  logic                 busy, done;

  warp_lsu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_if ();

  warp_lsu #(.THREADS_PER_WARP(T), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .decoded_immediate        (imm),
    .thread_enable            (mask),
    .rs1                      (rs1),
    .rs2                      (rs2),
    .mem                      (mem_if),
    .lsu_out                  (lsu_out),
    .busy                     (busy),
    .done                     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    int            tid;
  } req_t;

  req_t                 exp_q[$];
  logic [T-1:0][DW-1:0] lsu_exp;
  int                   checks = 0;
  int                   errors = 0;
  int                   done_cyc, req_cnt;
  logic                 busy_at1;
  logic [AW-1:0]        first_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ops();
    req_t e;
    exp_q.delete();
    if (rd_en || wr_en) begin
      for (int i = 0; i < int'(T); i++) begin
        if (mask[i]) begin
          e.addr  = AW'(rs1[i] + imm);
          e.write = !rd_en;
          e.wdata = rs2[i];
          e.tid   = i;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < int'(T); i++) begin
      rs1[i] = $urandom;
      rs2[i] = $urandom;
    end
    imm   = $urandom;
    mask  = T'($urandom);
    rd_en = 1'($urandom);
    wr_en = 1'($urandom);
  endtask

  task automatic check_lsu(input string name);
    for (int i = 0; i < int'(T); i++) begin
      checks++;
      if (lsu_out[i] !== lsu_exp[i]) begin
        errors++;
        $display("FAIL %s lsu_out[%0d]: got %h expected %h", name, i, lsu_out[i], lsu_exp[i]);
      end
    end
  endtask

  // Drives one warp operation from the current inputs and acts as the memory.
  task automatic run_op(input string name, input int stall, input bit stray,
                        input int busy_start_at, input bit use_fixed,
                        input logic [DW-1:0] rdata_fixed);
    int            cyc, stall_left;
    bit            rsp_next, in_req;
    logic [DW-1:0] rdata_next, hold_wdata;
    logic [AW-1:0] hold_addr;
    logic          hold_write;
    req_t          e;
    expect_ops();
    done_cyc = -1; req_cnt = 0; stall_left = stall; rsp_next = 0; in_req = 0;
    rdata_next = '0; hold_addr = '0; hold_wdata = '0; hold_write = 1'b0;
    first_addr = '0; busy_at1 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    cyc = 1;
    while (cyc < 300) begin
      if (cyc == 1) busy_at1 = busy;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = (cyc == busy_start_at);
      mem_if.mem_rsp_valid = rsp_next;
      mem_if.mem_rsp_rdata = rsp_next ? rdata_next : 32'h0BAD0BAD;
      rsp_next = 0;
      mem_if.mem_req_ready = 1'b0;
      if (mem_if.mem_req_valid) begin
        if (in_req) begin
          checks++;
          if (mem_if.mem_req_addr !== hold_addr || mem_if.mem_req_wdata !== hold_wdata ||
              mem_if.mem_req_write !== hold_write) begin
            errors++;
            $display("FAIL %s req_hold: got addr %h wdata %h write %b expected addr %h wdata %h write %b",
                     name, mem_if.mem_req_addr, mem_if.mem_req_wdata, mem_if.mem_req_write,
                     hold_addr, hold_wdata, hold_write);
          end
        end else begin
          hold_addr  = mem_if.mem_req_addr;
          hold_wdata = mem_if.mem_req_wdata;
          hold_write = mem_if.mem_req_write;
          in_req     = 1;
        end
        if (stall_left > 0) begin
          stall_left--;
          if (stray) mem_if.mem_rsp_valid = 1'b1;
        end else begin
          mem_if.mem_req_ready = 1'b1;
          in_req = 0;
          if (req_cnt == 0) first_addr = mem_if.mem_req_addr;
          req_cnt++;
          rdata_next = use_fixed ? rdata_fixed : DW'($urandom);
          rsp_next = 1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s req_extra: got addr %h expected no request", name, mem_if.mem_req_addr);
          end else begin
            e = exp_q.pop_front();
            if (mem_if.mem_req_addr !== e.addr || mem_if.mem_req_write !== e.write ||
                mem_if.mem_req_wdata !== e.wdata) begin
              errors++;
              $display("FAIL %s req: got addr %h write %b wdata %h expected addr %h write %b wdata %h",
                       name, mem_if.mem_req_addr, mem_if.mem_req_write, mem_if.mem_req_wdata,
                       e.addr, e.write, e.wdata);
            end
            if (!e.write) lsu_exp[e.tid] = rdata_next;
          end
        end
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_req_ready = 1'b0;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL %s timeout: got no done expected done within 300 cycles", name);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s req_missing: got %0d outstanding expected 0", name, exp_q.size());
    end
    exp_q.delete();
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done %b busy %b expected 0 0", name, done, busy);
    end
    check_lsu(name);
  endtask

  task automatic check_cyc(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    lsu_exp = '0;
    checks++;
    if (mem_if.mem_req_valid !== 1'b0 || mem_if.mem_req_write !== 1'b0 ||
        mem_if.mem_req_addr !== '0 || mem_if.mem_req_wdata !== '0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid %b write %b addr %h wdata %h busy %b done %b expected all 0",
               mem_if.mem_req_valid, mem_if.mem_req_write, mem_if.mem_req_addr,
               mem_if.mem_req_wdata, busy, done);
    end
    check_lsu("reset");
  endtask

  task automatic test_single_load();
    rs1 = '0; rs2 = '0;
    rs1[0] = 32'h100; imm = 32'h4; mask = 16'h0001; rd_en = 1'b1; wr_en = 1'b0;
    run_op("single_load", 0, 0, -1, 1, 32'hDEAD);
    check_cyc("single_load done_cycle", done_cyc, 3);
    check_cyc("single_load req_count", req_cnt, 1);
    checks++;
    if (first_addr !== 32'h104 || lsu_out[0] !== 32'hDEAD) begin
      errors++;
      $display("FAIL single_load addr_data: got addr %h data %h expected 00000104 0000dead",
               first_addr, lsu_out[0]);
    end
  endtask

  task automatic test_store();
    for (int i = 0; i < int'(T); i++) begin
      rs1[i] = 32'h1000 + 32'(i * 16);
      rs2[i] = 32'(i + 1);
    end
    imm = 32'h0; mask = 16'h8005; rd_en = 1'b0; wr_en = 1'b1;
    run_op("store", 0, 0, -1, 0, '0);
    check_cyc("store done_cycle", done_cyc, 7);
    check_cyc("store req_count", req_cnt, 3);
  endtask

  task automatic test_empty();
    mask = 16'h0000; rd_en = 1'b1; wr_en = 1'b0;
    run_op("empty_mask", 0, 0, -1, 0, '0);
    check_cyc("empty_mask done_cycle", done_cyc, 1);
    check_cyc("empty_mask req_count", req_cnt, 0);
    check_cyc("empty_mask busy_at1", int'(busy_at1), 1);
    mask = 16'hFFFF; rd_en = 1'b0; wr_en = 1'b0;
    run_op("no_op", 0, 0, -1, 0, '0);
    check_cyc("no_op done_cycle", done_cyc, 1);
    check_cyc("no_op req_count", req_cnt, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < int'(T); i++) rs1[i] = $urandom;
    imm = $urandom; mask = 16'h0010; rd_en = 1'b1; wr_en = 1'b0;
    run_op("backpressure", 3, 1, -1, 0, '0);
    check_cyc("backpressure done_cycle", done_cyc, 6);
    check_cyc("backpressure req_count", req_cnt, 1);
  endtask

  task automatic test_wrap();
    rs1[3] = 32'hFFFFFFFC; imm = 32'h8; mask = 16'h0008; rd_en = 1'b1; wr_en = 1'b0;
    run_op("wrap", 0, 0, 2, 0, '0);
    check_cyc("wrap done_cycle", done_cyc, 3);
    check_cyc("wrap req_count", req_cnt, 1);
    checks++;
    if (first_addr !== 32'h00000004) begin
      errors++;
      $display("FAIL wrap addr: got %h expected 00000004", first_addr);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < int'(T); i++) begin
      rs1[i] = $urandom; rs2[i] = $urandom;
    end
    imm = $urandom; mask = 16'hFFFF; rd_en = 1'b1; wr_en = 1'b0;
    run_op("full_load", 0, 0, -1, 0, '0);
    check_cyc("full_load done_cycle", done_cyc, 33);
    for (int i = 0; i < int'(T); i++) rs1[i] = $urandom;
    imm = $urandom; mask = 16'h5A3C; rd_en = 1'b1; wr_en = 1'b1;
    run_op("rw_load", 0, 0, -1, 0, '0);
    check_cyc("rw_load done_cycle", done_cyc, 17);
  endtask

  task automatic test_reset_mid();
    rs1[1] = 32'h2000; imm = 32'h0; mask = 16'h0002; rd_en = 1'b1; wr_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lsu_exp = '0;
    checks++;
    if (mem_if.mem_req_valid !== 1'b0 || mem_if.mem_req_addr !== '0 ||
        mem_if.mem_req_wdata !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid outputs: got valid %b addr %h wdata %h busy %b done %b expected all 0",
               mem_if.mem_req_valid, mem_if.mem_req_addr, mem_if.mem_req_wdata, busy, done);
    end
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_rdata = 32'h12345678;
    tick();
    mem_if.mem_rsp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || mem_if.mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid late_rsp: got done %b busy %b valid %b expected 0 0 0",
                 done, busy, mem_if.mem_req_valid);
      end
      tick();
    end
    check_lsu("reset_mid");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    imm = '0; mask = '0; rs1 = '0; rs2 = '0; lsu_exp = '0;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_rdata = '0;
    test_reset();
    test_single_load();
    test_store();
    test_empty();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
